alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: ALU_LAT, default 1, number of EXEC cycles the ALU inputs are held before alu_result is sampled; legal range 1..15.
REQ-002 SHALL have ports (name direction width meaning):
- clock  in  1  sole clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- req_valid  in  1  operation request valid
- req_ready  out  1  controller can accept a request
- req_opcode  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 NOT, 0011 NEG, 0100 ADD, 0101 SUB, 0110 MUL, 0111 DIV, 1000 SHR, 1001 SHRA, 1010 SHL, 1011 ROR, 1100 ROL
- req_ra  in  4  register index, operand A
- req_rb  in  4  register index, operand B
- req_rz  in  4  destination register index
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  4  register-file read index
- rf_rd_data  in  32  read data, valid the cycle after rf_rd_en
- alu_A  out  32  ALU operand A, registered
- alu_B  out  32  ALU operand B, registered
- alu_opcode  out  4  ALU opcode, registered
- alu_result  in  32  ALU combinational result
- wb_valid  out  1  write-back valid
- wb_ready  in  1  write-back accept
- wb_addr  out  4  destination index
- wb_data  out  32  captured result
- illegal  out  1  one-cycle pulse on a rejected opcode
REQ-003 SHALL use clock as the only clock and clear as an asynchronous, active-high reset.

Function
REQ-004 SHALL implement states IDLE, RDA, RDB, CAPB, EXEC and WB; req_ready SHALL be 1 only in IDLE.
REQ-005 Handshake: on a cycle with req_valid=1 in IDLE, the request SHALL be accepted (cycle 0), and opcode, ra, rb and rz SHALL be latched.
REQ-006 If the accepted opcode is greater than 4'b1100, the block SHALL pulse illegal in cycle 1, remain in IDLE, and issue no register-file read.
REQ-007 RDA (cycle 1): rf_rd_en=1, rf_rd_addr=ra.
REQ-008 RDB (cycle 2): rf_rd_data SHALL be loaded into alu_A; rf_rd_en=1, rf_rd_addr=rb, except for NOT and NEG (0010, 0011), where rf_rd_en=0.
REQ-009 CAPB (cycle 3): alu_B SHALL load rf_rd_data, or 32'h0 for NOT and NEG; alu_opcode SHALL load the latched opcode.
REQ-010 EXEC SHALL last exactly ALU_LAT cycles (4-bit down-counter) with alu_A, alu_B and alu_opcode held stable; at the end of the last EXEC cycle, wb_data SHALL load alu_result and wb_addr SHALL load rz.
REQ-011 wb_valid SHALL first assert in cycle 4+ALU_LAT (cycle 5 for default ALU_LAT=1).
REQ-012 wb_valid, wb_data and wb_addr SHALL be held stable until a cycle where wb_valid and wb_ready are both 1; the state SHALL be IDLE the next cycle, with wb_valid=0.
REQ-013 req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-014 rf_rd_en SHALL be 0 in IDLE, CAPB, EXEC and WB.
REQ-015 ra equal to rb, or rz equal to ra or rb, SHALL need no special handling; reads return register-file contents as is.
REQ-016 A wb_ready held at 1 before WB SHALL complete the write-back in the first WB cycle.

Reset
REQ-017 When clear=1, at any time or state, the block SHALL go to IDLE and zero all outputs except req_ready, and zero the EXEC counter and latched fields; an in-flight request SHALL be discarded with no wb_valid.
REQ-018 req_ready SHALL be 1 while in IDLE after reset; the first request SHALL be accepted on the first rising edge after clear falls.

Verification
REQ-019 ADD with ra=1 (32'h0000_0005), rb=2 (32'h0000_0003), rz=4, ALU_LAT=1 SHALL assert wb_valid in cycle 5 with wb_data=32'h0000_0008, wb_addr=4.
REQ-020 NEG with ra=3 (32'h0000_0001) SHALL produce exactly one read (addr 3), alu_B=0, and wb_data=32'hFFFF_FFFF.
REQ-021 Opcode 4'b1111 SHALL produce illegal=1 in cycle 1 only, no rf_rd_en, no wb_valid, and req_ready=1 in cycle 1.
REQ-022 With wb_ready=0 for 4 cycles in WB, wb_valid/wb_data SHALL stay constant; when wb_ready=1, IDLE SHALL follow next cycle; req_valid pulses during the stall SHALL be ignored.
REQ-023 clear asserted mid-EXEC SHALL zero all outputs asynchronously, produce no wb_valid, and a new request SHALL then complete normally.
REQ-024 With ALU_LAT=3, the inputs SHALL be held for 3 cycles and wb_valid SHALL first assert in cycle 7.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one ALU request at a time, reads operand A
// and B from the register file, holds the ALU inputs for ALU_LAT cycles,
// then presents the captured result on a valid/ready write-back port.
//
// state | meaning
// IDLE  | ready for a request; illegal opcodes are rejected here
// RDA   | read strobe for operand A (ra)
// RDB   | capture A, read strobe for operand B (rb) unless unary op
// CAPB  | capture B (or zero for NOT/NEG) and the opcode into the ALU inputs
// EXEC  | hold ALU inputs for ALU_LAT cycles, capture result on the last one
// WB    | hold write-back until wb_ready
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [3:0]  req_ra,
    input  logic [3:0]  req_rb,
    input  logic [3:0]  req_rz,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        CAPB = 3'd3,
        EXEC = 3'd4,
        WB   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_NEG = 4'b0011;
    localparam logic [3:0] OP_MAX = 4'b1100;
    // EXEC counts down from ALU_LAT-1 to 0, so it lasts ALU_LAT cycles
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] op_q, ra_q, rb_q, rz_q;
    logic [3:0] lat_cnt;
    logic       accept, cap_a, cap_b, exec_done;
    logic       unary;

    // NOT and NEG only use operand A
    assign unary = (op_q == OP_NOT) || (op_q == OP_NEG);

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and the combinational handshake/read outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = 4'd0;
        wb_valid   = 1'b0;
        accept     = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        exec_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_opcode <= OP_MAX) state_nxt = RDA;
                end
            end
            RDA: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = ra_q;
                state_nxt  = RDB;
            end
            RDB: begin
                cap_a = 1'b1;
                if (!unary) begin
                    rf_rd_en   = 1'b1;
                    rf_rd_addr = rb_q;
                end
                state_nxt = CAPB;
            end
            CAPB: begin
                cap_b     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (lat_cnt == 4'd0) begin
                    exec_done = 1'b1;
                    state_nxt = WB;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields, ALU operand registers, latency counter and write-back data
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q       <= 4'd0;
            ra_q       <= 4'd0;
            rb_q       <= 4'd0;
            rz_q       <= 4'd0;
            lat_cnt    <= 4'd0;
            alu_A      <= 32'd0;
            alu_B      <= 32'd0;
            alu_opcode <= 4'd0;
            wb_addr    <= 4'd0;
            wb_data    <= 32'd0;
            illegal    <= 1'b0;
        end else begin
            illegal <= accept && (req_opcode > OP_MAX);
            if (accept) begin
                op_q <= req_opcode;
                ra_q <= req_ra;
                rb_q <= req_rb;
                rz_q <= req_rz;
            end
            if (cap_a) alu_A <= rf_rd_data;
            if (cap_b) begin
                alu_B      <= unary ? 32'd0 : rf_rd_data;
                alu_opcode <= op_q;
                lat_cnt    <= LAT_M1;
            end else if (state == EXEC && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (exec_done) begin
                wb_data <= alu_result;
                wb_addr <= rz_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a registered-read register file model,
// a combinational ALU model, one instance at ALU_LAT=1 and one at ALU_LAT=3.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic [3:0]  req_opcode, req_ra, req_rb, req_rz;

    logic        req_valid, req_ready, rf_rd_en, wb_valid, wb_ready, illegal;
    logic [3:0]  rf_rd_addr, alu_opcode, wb_addr;
    logic [31:0] rf_rd_data, alu_A, alu_B, alu_result, wb_data;

    logic        req_valid_3, req_ready_3, rf_rd_en_3, wb_valid_3, wb_ready_3, illegal_3;
    logic [3:0]  rf_rd_addr_3, alu_opcode_3, wb_addr_3;
    logic [31:0] rf_rd_data_3, alu_A_3, alu_B_3, alu_result_3, wb_data_3;

    logic [31:0] regs [16];
    int          rd_count = 0;
    logic [3:0]  last_rd_addr = 4'd0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rd0;

    alu_issue_ctrl #(.ALU_LAT(1)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb), .req_rz(req_rz),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal)
    );

    alu_issue_ctrl #(.ALU_LAT(3)) dut3 (
        .clock(clock), .clear(clear),
        .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb), .req_rz(req_rz),
        .rf_rd_en(rf_rd_en_3), .rf_rd_addr(rf_rd_addr_3), .rf_rd_data(rf_rd_data_3),
        .alu_A(alu_A_3), .alu_B(alu_B_3), .alu_opcode(alu_opcode_3), .alu_result(alu_result_3),
        .wb_valid(wb_valid_3), .wb_ready(wb_ready_3), .wb_addr(wb_addr_3), .wb_data(wb_data_3),
        .illegal(illegal_3)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~a;
            4'd3:    return -a;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return a * b;
            4'd7:    return (b == 32'd0) ? 32'd0 : a / b;
            4'd8:    return a >> s;
            4'd9:    return $signed(a) >>> s;
            4'd10:   return a << s;
            4'd11:   return (s == 5'd0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
            4'd12:   return (s == 5'd0) ? a : ((a << s) | (a >> (6'd32 - {1'b0, s})));
            default: return 32'd0;
        endcase
    endfunction

    // Combinational ALU stand-ins
    always_comb alu_result   = alu_f(alu_opcode, alu_A, alu_B);
    always_comb alu_result_3 = alu_f(alu_opcode_3, alu_A_3, alu_B_3);

    // Register file with one-cycle read latency; counts reads of the LAT=1 instance
    always @(posedge clock) begin
        if (rf_rd_en) begin
            rf_rd_data   <= regs[rf_rd_addr];
            rd_count     <= rd_count + 1;
            last_rd_addr <= rf_rd_addr;
        end
        if (rf_rd_en_3) rf_rd_data_3 <= regs[rf_rd_addr_3];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [3:0] rz);
        req_valid  = 1'b1;
        req_opcode = op;
        req_ra     = ra;
        req_rb     = rb;
        req_rz     = rz;
    endtask

    // Issue one request in the current cycle (cycle 0) with wb_ready high; end in cycle 6
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [3:0] rz,
                          input logic [31:0] exp_b, input logic [31:0] exp_data);
        wb_ready = 1'b1;
        drive_req(op, ra, rb, rz);
        chk({tag, "_c0_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        chk({tag, "_c1_rden"}, rf_rd_en, 1);
        chk({tag, "_c1_addr"}, rf_rd_addr, ra);
        chk({tag, "_c1_illegal"}, illegal, 0);
        step();
        step();
        step();
        chk({tag, "_c4_b"}, alu_B, exp_b);
        chk({tag, "_c4_wbv"}, wb_valid, 0);
        step();
        chk({tag, "_c5_wbv"}, wb_valid, 1);
        chk({tag, "_c5_data"}, wb_data, exp_data);
        chk({tag, "_c5_addr"}, wb_addr, rz);
        step();
        chk({tag, "_c6_wbv"}, wb_valid, 0);
        chk({tag, "_c6_ready"}, req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        regs[1] = 32'h0000_0005;
        regs[2] = 32'h0000_0003;
        regs[3] = 32'h0000_0001;
        regs[5] = 32'h0000_00F0;
        clear       = 1'b1;
        req_valid   = 1'b0;
        req_valid_3 = 1'b0;
        wb_ready    = 1'b0;
        wb_ready_3  = 1'b0;
        req_opcode  = 4'd0;
        req_ra      = 4'd0;
        req_rb      = 4'd0;
        req_rz      = 4'd0;
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_rden", rf_rd_en, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_alu_a", alu_A, 0);
        chk("rst_illegal", illegal, 0);
        step();
        clear = 1'b0;

        // ADD r1+r2 -> r4, wb_ready already high: write-back in cycle 5
        wb_ready = 1'b1;
        drive_req(4'b0100, 4'd1, 4'd2, 4'd4);
        chk("add_c0_ready", req_ready, 1);
        chk("add_c0_rden", rf_rd_en, 0);
        step();
        req_valid = 1'b0;
        chk("add_c1_rden", rf_rd_en, 1);
        chk("add_c1_addr", rf_rd_addr, 4'd1);
        chk("add_c1_ready", req_ready, 0);
        step();
        chk("add_c2_rden", rf_rd_en, 1);
        chk("add_c2_addr", rf_rd_addr, 4'd2);
        step();
        chk("add_c3_rden", rf_rd_en, 0);
        chk("add_c3_a", alu_A, 32'h5);
        step();
        chk("add_c4_b", alu_B, 32'h3);
        chk("add_c4_op", alu_opcode, 4'b0100);
        chk("add_c4_wbv", wb_valid, 0);
        step();
        chk("add_c5_wbv", wb_valid, 1);
        chk("add_c5_data", wb_data, 32'h8);
        chk("add_c5_addr", wb_addr, 4'd4);
        step();
        chk("add_c6_wbv", wb_valid, 0);
        chk("add_c6_ready", req_ready, 1);

        // NEG r3: single read of r3, B forced to zero
        rd0 = rd_count;
        run_op("neg", 4'b0011, 4'd3, 4'd7, 4'd9, 32'h0, 32'hFFFF_FFFF);
        chk("neg_reads", 32'(rd_count - rd0), 32'd1);
        chk("neg_rdaddr", last_rd_addr, 4'd3);

        // Highest legal opcode (ROL), rz equal to ra: 0xF0 rol 1
        run_op("rol", 4'b1100, 4'd5, 4'd3, 4'd5, 32'h1, 32'h0000_01E0);
        // ra equal to rb
        run_op("or_same", 4'b0001, 4'd1, 4'd1, 4'd1, 32'h5, 32'h5);

        // Illegal opcode: pulse in cycle 1 only, stay idle, no reads
        rd0 = rd_count;
        drive_req(4'b1111, 4'd1, 4'd2, 4'd3);
        step();
        req_valid = 1'b0;
        chk("ill_c1_pulse", illegal, 1);
        chk("ill_c1_ready", req_ready, 1);
        chk("ill_c1_rden", rf_rd_en, 0);
        step();
        chk("ill_c2_pulse", illegal, 0);
        chk("ill_c2_rden", rf_rd_en, 0);
        step();
        step();
        chk("ill_wbv", wb_valid, 0);
        chk("ill_reads", 32'(rd_count - rd0), 32'd0);

        // SUB r1-r2 -> r6 with four stalled WB cycles and ignored req_valid pulses
        rd0 = rd_count;
        wb_ready = 1'b0;
        drive_req(4'b0101, 4'd1, 4'd2, 4'd6);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_wbv", wb_valid, 1);
            chk("stall_data", wb_data, 32'h2);
            chk("stall_addr", wb_addr, 4'd6);
            chk("stall_ready", req_ready, 0);
            chk("stall_rden", rf_rd_en, 0);
            if (i == 1 || i == 3) drive_req(4'b0100, 4'd5, 4'd5, 4'd0);
            else req_valid = 1'b0;
            step();
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        chk("stall_rel_wbv", wb_valid, 1);
        chk("stall_rel_data", wb_data, 32'h2);
        step();
        chk("stall_done_wbv", wb_valid, 0);
        chk("stall_done_ready", req_ready, 1);
        chk("stall_done_rden", rf_rd_en, 0);
        chk("stall_reads", 32'(rd_count - rd0), 32'd2);

        // clear in the middle of EXEC, then a new request right after release
        drive_req(4'b0100, 4'd1, 4'd2, 4'd4);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        clear = 1'b1;
        #1;
        chk("clr_alu_a", alu_A, 0);
        chk("clr_alu_b", alu_B, 0);
        chk("clr_alu_op", alu_opcode, 0);
        chk("clr_wbv", wb_valid, 0);
        chk("clr_wbdata", wb_data, 0);
        chk("clr_ready", req_ready, 1);
        step();
        chk("clr_held_wbv", wb_valid, 0);
        clear = 1'b0;
        run_op("post_clr", 4'b0100, 4'd5, 4'd5, 4'd2, 32'hF0, 32'h0000_01E0);

        // ALU_LAT=3 instance: inputs held cycles 4..6, write-back in cycle 7
        wb_ready_3  = 1'b1;
        req_valid_3 = 1'b1;
        req_opcode  = 4'b0100;
        req_ra      = 4'd1;
        req_rb      = 4'd2;
        req_rz      = 4'd4;
        step();
        req_valid_3 = 1'b0;
        step();
        step();
        step();
        for (int c = 4; c < 7; c++) begin
            chk("lat3_a", alu_A_3, 32'h5);
            chk("lat3_b", alu_B_3, 32'h3);
            chk("lat3_op", alu_opcode_3, 4'b0100);
            chk("lat3_wbv_early", wb_valid_3, 0);
            step();
        end
        chk("lat3_c7_wbv", wb_valid_3, 1);
        chk("lat3_c7_data", wb_data_3, 32'h8);
        chk("lat3_c7_addr", wb_addr_3, 4'd4);
        step();
        chk("lat3_c8_wbv", wb_valid_3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
